// File: rtl/dsp_slave_pkg.sv
// Shared definitions for the DSP Wishbone slave: register index map, CTRL/STATUS bit
// positions, parameter range limits and the index decoder.
package dsp_slave_pkg;

    // Register indices (wb_adr_i[7:2])
    localparam int unsigned IdxCtrl    = 0;
    localparam int unsigned IdxStatus  = 1;
    localparam int unsigned IdxInBase  = 2;
    localparam int unsigned IdxOutBase = 16;

    // CTRL / STATUS bit positions
    localparam int unsigned CtrlStartBit = 0;
    localparam int unsigned CtrlIrqEnBit = 1;
    localparam int unsigned StatDoneBit  = 0;
    localparam int unsigned StatBusyBit  = 1;

    // Legal ranges for the register-count parameters
    localparam int unsigned NumInMin  = 1;
    localparam int unsigned NumInMax  = 14;
    localparam int unsigned NumOutMin = 1;
    localparam int unsigned NumOutMax = 16;

    typedef enum logic [2:0] {
        RegCtrl,
        RegStatus,
        RegIn,
        RegOut,
        RegNone
    } reg_kind_e;

    function automatic reg_kind_e decode_idx(input int unsigned idx,
                                             input int unsigned num_in,
                                             input int unsigned num_out);
        if (idx == IdxCtrl)   return RegCtrl;
        if (idx == IdxStatus) return RegStatus;
        if (idx >= IdxInBase && idx < IdxInBase + num_in)    return RegIn;
        if (idx >= IdxOutBase && idx < IdxOutBase + num_out) return RegOut;
        return RegNone;
    endfunction

endpackage

// File: rtl/dsp_slave_bereg.sv
// DW-wide register with per-byte write enables and asynchronous active-low reset.
// Ports: clk, rst_n, we (write strobe), sel (byte enables), d (write data), q (contents).
module dsp_slave_bereg #(
    parameter int unsigned DW = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            we,
    input  logic [DW/8-1:0] sel,
    input  logic [DW-1:0]   d,
    output logic [DW-1:0]   q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (we) begin
            for (int unsigned b = 0; b < DW / 8; b++) begin
                if (sel[b]) q[b*8 +: 8] <= d[b*8 +: 8];
            end
        end
    end

endmodule

// File: rtl/dsp_slave_param.sv
// Wishbone slave exposing a DSP core: CTRL, STATUS, NUM_IN read/write input registers and
// NUM_OUT read-only output registers, with start/busy/done handshake and a level interrupt.
// Ports: wb_* Wishbone slave (classic + incrementing burst), dsp_in_o flattened inputs,
// dsp_out_i flattened outputs, done_i completion level, start_o start pulse, busy_o, irq_o.
module dsp_slave_param
    import dsp_slave_pkg::*;
#(
    parameter int unsigned DW            = 32,
    parameter int unsigned AW            = 32,
    parameter int unsigned NUM_IN        = 5,
    parameter int unsigned NUM_OUT       = 5,
    parameter logic [31:0] SLAVE_ADDRESS = 32'h0000_0000
) (
    input  logic                  wb_clk,
    input  logic                  wb_rst_n,
    input  logic [AW-1:0]         wb_adr_i,
    input  logic [DW-1:0]         wb_dat_i,
    input  logic [DW/8-1:0]       wb_sel_i,
    input  logic                  wb_we_i,
    input  logic                  wb_cyc_i,
    input  logic                  wb_stb_i,
    input  logic [2:0]            wb_cti_i,
    input  logic [1:0]            wb_bte_i,
    output logic [DW-1:0]         wb_dat_o,
    output logic                  wb_ack_o,
    output logic                  wb_err_o,
    output logic                  wb_rty_o,
    output logic [NUM_IN*DW-1:0]  dsp_in_o,
    input  logic [NUM_OUT*DW-1:0] dsp_out_i,
    input  logic                  done_i,
    output logic                  start_o,
    output logic                  busy_o,
    output logic                  irq_o
);

    if (NUM_IN < NumInMin || NUM_IN > NumInMax) begin : g_bad_num_in
        $error("NUM_IN out of range");
    end
    if (NUM_OUT < NumOutMin || NUM_OUT > NumOutMax) begin : g_bad_num_out
        $error("NUM_OUT out of range");
    end

    // Only IRQ_EN is storable in CTRL; START is a strobe and never held.
    localparam logic [DW-1:0] CtrlMask = DW'(1) << CtrlIrqEnBit;

    int unsigned   idx_i;
    reg_kind_e     kind;
    logic          access, bad, wr_ok;
    logic          start_wr, done_clr, done_rise;
    logic [DW-1:0] rdata;
    logic [DW-1:0] ctrl_q;
    logic [DW-1:0] in_q [NUM_IN];
    logic          ack_q, err_q, burst_q, start_pend_q, start_q;
    logic          busy_q, done_q, done_prev_q, irq_q;
    logic [DW-1:0] dat_q;
    logic          unused_inputs;

    assign unused_inputs = ^{wb_bte_i, wb_adr_i[AW-1:8], wb_adr_i[1:0], SLAVE_ADDRESS};

    assign idx_i = 32'(wb_adr_i[7:2]);
    assign kind  = decode_idx(idx_i, NUM_IN, NUM_OUT);

    // While the previous beat was an incrementing burst, a new beat is accepted in the
    // same cycle its predecessor is acked, giving one ack per cycle.
    assign access = wb_cyc_i & wb_stb_i & ~wb_err_o & (~wb_ack_o | burst_q);
    assign bad    = (kind == RegNone) | ((kind == RegOut) & wb_we_i);
    assign wr_ok  = access & ~bad & wb_we_i;

    assign start_wr  = wr_ok & (kind == RegCtrl) & wb_sel_i[0] & wb_dat_i[CtrlStartBit];
    assign done_clr  = wr_ok & (kind == RegStatus) & wb_sel_i[0] & wb_dat_i[StatDoneBit];
    assign done_rise = done_i & ~done_prev_q;

    for (genvar k = 0; k < NUM_IN; k++) begin : g_in
        dsp_slave_bereg #(.DW(DW)) u_in_reg (
            .clk   (wb_clk),
            .rst_n (wb_rst_n),
            .we    (wr_ok && (idx_i == IdxInBase + k)),
            .sel   (wb_sel_i),
            .d     (wb_dat_i),
            .q     (in_q[k])
        );
        assign dsp_in_o[k*DW +: DW] = in_q[k];
    end

    dsp_slave_bereg #(.DW(DW)) u_ctrl_reg (
        .clk   (wb_clk),
        .rst_n (wb_rst_n),
        .we    (wr_ok && (kind == RegCtrl)),
        .sel   (wb_sel_i),
        .d     (wb_dat_i & CtrlMask),
        .q     (ctrl_q)
    );

    always_comb begin
        rdata = '0;
        unique case (kind)
            RegCtrl:   rdata = ctrl_q & CtrlMask;
            RegStatus: begin
                rdata[StatDoneBit] = done_q;
                rdata[StatBusyBit] = busy_q;
            end
            RegIn: begin
                for (int unsigned k = 0; k < NUM_IN; k++) begin
                    if (idx_i == IdxInBase + k) rdata = in_q[k];
                end
            end
            RegOut: begin
                for (int unsigned k = 0; k < NUM_OUT; k++) begin
                    if (idx_i == IdxOutBase + k) rdata = dsp_out_i[k*DW +: DW];
                end
            end
            default: rdata = '0;
        endcase
    end

    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            ack_q        <= 1'b0;
            err_q        <= 1'b0;
            dat_q        <= '0;
            burst_q      <= 1'b0;
            start_pend_q <= 1'b0;
            start_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            done_prev_q  <= 1'b0;
            irq_q        <= 1'b0;
        end else begin
            ack_q        <= access & ~bad;
            err_q        <= access & bad;
            dat_q        <= (access & ~bad & ~wb_we_i) ? rdata : '0;
            burst_q      <= access & (wb_cti_i == 3'b010);
            // START is accepted on the access edge; the pulse follows the ack cycle.
            start_pend_q <= start_wr;
            start_q      <= start_pend_q;
            if (start_pend_q)   busy_q <= 1'b1;
            else if (done_rise) busy_q <= 1'b0;
            if (done_rise)      done_q <= 1'b1;
            else if (done_clr)  done_q <= 1'b0;
            done_prev_q  <= done_i;
            irq_q        <= done_q & ctrl_q[CtrlIrqEnBit];
        end
    end

    assign wb_ack_o = ack_q;
    assign wb_err_o = err_q;
    assign wb_dat_o = dat_q;
    assign wb_rty_o = 1'b0;
    assign start_o  = start_q;
    assign busy_o   = busy_q;
    assign irq_o    = irq_q;

endmodule

// File: tb/tb_dsp_slave_param.sv
module tb_dsp_slave_param;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int NI = 5;
    localparam int NO = 5;

    logic                wb_clk = 1'b0;
    logic                wb_rst_n = 1'b0;
    logic [AW-1:0]       wb_adr_i = '0;
    logic [DW-1:0]       wb_dat_i = '0;
    logic [DW/8-1:0]     wb_sel_i = '0;
    logic                wb_we_i = 1'b0;
    logic                wb_cyc_i = 1'b0;
    logic                wb_stb_i = 1'b0;
    logic [2:0]          wb_cti_i = 3'b000;
    logic [1:0]          wb_bte_i = 2'b00;
    logic [DW-1:0]       wb_dat_o;
    logic                wb_ack_o, wb_err_o, wb_rty_o;
    logic [NI*DW-1:0]    dsp_in_o;
    logic [NO*DW-1:0]    dsp_out_i = {32'd5, 32'd4, 32'd3, 32'd2, 32'd1};
    logic                done_i = 1'b0;
    logic                start_o, busy_o, irq_o;

    always #5 wb_clk = ~wb_clk;

    dsp_slave_param #(
        .DW(DW), .AW(AW), .NUM_IN(NI), .NUM_OUT(NO), .SLAVE_ADDRESS(32'h0000_0000)
    ) dut (
        .wb_clk    (wb_clk),
        .wb_rst_n  (wb_rst_n),
        .wb_adr_i  (wb_adr_i),
        .wb_dat_i  (wb_dat_i),
        .wb_sel_i  (wb_sel_i),
        .wb_we_i   (wb_we_i),
        .wb_cyc_i  (wb_cyc_i),
        .wb_stb_i  (wb_stb_i),
        .wb_cti_i  (wb_cti_i),
        .wb_bte_i  (wb_bte_i),
        .wb_dat_o  (wb_dat_o),
        .wb_ack_o  (wb_ack_o),
        .wb_err_o  (wb_err_o),
        .wb_rty_o  (wb_rty_o),
        .dsp_in_o  (dsp_in_o),
        .dsp_out_i (dsp_out_i),
        .done_i    (done_i),
        .start_o   (start_o),
        .busy_o    (busy_o),
        .irq_o     (irq_o)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Register file plus flags; a write seen by the model is the one the driver presents
    // during the cycle that ends at the next rising edge.
    logic [DW-1:0] m_in [NI];
    logic          m_irq_en, m_done, m_busy, m_irq, m_start, m_start_req, m_done_prev;
    logic          mw_valid = 1'b0;
    logic [5:0]    mw_idx = '0;
    logic [31:0]   mw_data = '0;
    logic [3:0]    mw_sel = '0;

    always @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            for (int k = 0; k < NI; k++) m_in[k] <= '0;
            m_irq_en <= 0; m_done <= 0; m_busy <= 0; m_irq <= 0;
            m_start <= 0; m_start_req <= 0; m_done_prev <= 0;
        end else begin
            m_start_req <= mw_valid && mw_idx == 0 && mw_sel[0] && mw_data[0];
            m_start     <= m_start_req;
            m_irq       <= m_done && m_irq_en;
            m_done_prev <= done_i;
            if (mw_valid && mw_idx == 0 && mw_sel[0]) m_irq_en <= mw_data[1];
            if (mw_valid && mw_idx >= 2 && mw_idx < 2 + NI)
                for (int b = 0; b < 4; b++)
                    if (mw_sel[b]) m_in[mw_idx - 2][b*8 +: 8] <= mw_data[b*8 +: 8];
            if (done_i && !m_done_prev) m_done <= 1;
            else if (mw_valid && mw_idx == 1 && mw_sel[0] && mw_data[0]) m_done <= 0;
            if (m_start_req) m_busy <= 1;
            else if (done_i && !m_done_prev) m_busy <= 0;
        end
    end

    function automatic logic [31:0] m_read(input logic [5:0] idx);
        if (idx == 0) return {30'b0, m_irq_en, 1'b0};
        if (idx == 1) return {30'b0, m_busy, m_done};
        if (idx >= 2 && idx < 2 + NI) return m_in[idx - 2];
        if (idx >= 16 && idx < 16 + NO) return dsp_out_i[(idx - 16) * DW +: DW];
        return 32'h0;
    endfunction

    function automatic bit m_err(input logic [5:0] idx, input bit we);
        return !(idx == 0 || idx == 1 || (idx >= 2 && idx < 2 + NI) ||
                 (idx >= 16 && idx < 16 + NO && !we));
    endfunction

    function automatic logic [NI*DW-1:0] m_flat();
        logic [NI*DW-1:0] f;
        for (int k = 0; k < NI; k++) f[k*DW +: DW] = m_in[k];
        return f;
    endfunction

    // Every-cycle comparison of the sideband outputs against the model.
    always @(negedge wb_clk) begin
        if (wb_rst_n) begin
            chk("start_o", 256'(start_o), 256'(m_start));
            chk("busy_o", 256'(busy_o), 256'(m_busy));
            chk("irq_o", 256'(irq_o), 256'(m_irq));
            chk("dsp_in_o", 256'(dsp_in_o), 256'(m_flat()));
            chk("wb_rty_o", 256'(wb_rty_o), 256'(0));
        end
    end

    // ---------------- driver ----------------
    task automatic bus(input string name, input logic [31:0] adr, input bit we,
                       input logic [31:0] dat, input logic [3:0] sel, output logic [31:0] rd);
        logic [5:0]  idx;
        bit          e;
        logic [31:0] ex;
        idx = adr[7:2];
        e   = m_err(idx, we);
        ex  = e ? 32'h0 : m_read(idx);
        wb_adr_i = adr; wb_we_i = we; wb_dat_i = dat; wb_sel_i = sel;
        wb_cti_i = 3'b000; wb_cyc_i = 1; wb_stb_i = 1;
        mw_valid = we; mw_idx = idx; mw_data = dat; mw_sel = sel;
        @(posedge wb_clk); #1;
        mw_valid = 0;
        chk({name, " ack"}, 256'(wb_ack_o), 256'(!e));
        chk({name, " err"}, 256'(wb_err_o), 256'(e));
        if (!we || e) chk({name, " data"}, 256'(wb_dat_o), 256'(ex));
        rd = wb_dat_o;
        wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0;
        @(posedge wb_clk); #1;
        chk({name, " single-cycle term"}, 256'(wb_ack_o | wb_err_o), 256'(0));
    endtask

    // Four-beat incrementing read burst; optionally asserts reset after the second beat.
    task automatic burst4(input logic [31:0] base, input bit rst_mid);
        logic [31:0] ex;
        wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = 0; wb_sel_i = 4'hF;
        for (int i = 0; i < 4; i++) begin
            wb_adr_i = base + 32'(4 * i);
            wb_cti_i = (i == 3) ? 3'b111 : 3'b010;
            ex = m_read(wb_adr_i[7:2]);
            @(posedge wb_clk); #1;
            chk("burst ack", 256'(wb_ack_o), 256'(1));
            chk("burst err", 256'(wb_err_o), 256'(0));
            chk("burst data model", 256'(wb_dat_o), 256'(ex));
            chk("burst data literal", 256'(wb_dat_o), 256'(i + 1));
            if (rst_mid && i == 1) begin
                #2 wb_rst_n = 0;
                #1;
                chk("rst ack", 256'(wb_ack_o), 256'(0));
                chk("rst err", 256'(wb_err_o), 256'(0));
                chk("rst dat", 256'(wb_dat_o), 256'(0));
                chk("rst start", 256'(start_o), 256'(0));
                chk("rst busy", 256'(busy_o), 256'(0));
                chk("rst irq", 256'(irq_o), 256'(0));
                chk("rst dsp_in", 256'(dsp_in_o), 256'(0));
                wb_cyc_i = 0; wb_stb_i = 0; wb_cti_i = 3'b000;
                return;
            end
        end
        wb_cyc_i = 0; wb_stb_i = 0; wb_cti_i = 3'b000;
        @(posedge wb_clk); #1;
        chk("burst end no ack", 256'(wb_ack_o), 256'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        repeat (3) @(posedge wb_clk);
        #1;
        chk("reset ack", 256'(wb_ack_o), 256'(0));
        chk("reset err", 256'(wb_err_o), 256'(0));
        chk("reset dat", 256'(wb_dat_o), 256'(0));
        chk("reset start", 256'(start_o), 256'(0));
        chk("reset busy", 256'(busy_o), 256'(0));
        chk("reset irq", 256'(irq_o), 256'(0));
        chk("reset dsp_in", 256'(dsp_in_o), 256'(0));
        wb_rst_n = 1;
        @(posedge wb_clk); #1;

        // Reset values
        bus("rd INPUT0", 32'h08, 0, 0, 4'hF, rd);
        chk("INPUT0 reset literal", 256'(rd), 256'(32'h0));
        bus("rd STATUS", 32'h04, 0, 0, 4'hF, rd);
        chk("STATUS reset literal", 256'(rd), 256'(32'h0));

        // Byte lanes
        bus("wr INPUT1", 32'h0C, 1, 32'hA5A5_A5A5, 4'b0101, rd);
        bus("rd INPUT1", 32'h0C, 0, 0, 4'hF, rd);
        chk("INPUT1 lanes literal", 256'(rd), 256'(32'h00A5_00A5));
        bus("wr INPUT0", 32'h08, 1, 32'h1234_5678, 4'hF, rd);
        bus("wr INPUT4", 32'h18, 1, 32'hDEAD_BEEF, 4'b1000, rd);
        bus("rd INPUT4", 32'h18, 0, 0, 4'hF, rd);
        chk("INPUT4 lane3 literal", 256'(rd), 256'(32'hDE00_0000));

        // Start / done / irq
        bus("wr CTRL start", 32'h00, 1, 32'h3, 4'hF, rd);
        chk("busy after start", 256'(busy_o), 256'(1));
        bus("rd CTRL", 32'h00, 0, 0, 4'hF, rd);
        chk("CTRL literal", 256'(rd), 256'(32'h2));
        done_i = 1;
        repeat (2) @(posedge wb_clk);
        #1;
        chk("irq after done literal", 256'(irq_o), 256'(1));
        done_i = 0;
        bus("rd STATUS done", 32'h04, 0, 0, 4'hF, rd);
        chk("STATUS done literal", 256'(rd), 256'(32'h1));
        bus("wr STATUS w1c", 32'h04, 1, 32'h1, 4'hF, rd);
        chk("irq cleared literal", 256'(irq_o), 256'(0));
        bus("rd STATUS cleared", 32'h04, 0, 0, 4'hF, rd);

        // Errors
        bus("rd unmapped 0x7C", 32'h7C, 0, 0, 4'hF, rd);
        bus("wr OUTPUT0", 32'h40, 1, 32'hFFFF_FFFF, 4'hF, rd);
        bus("wr unmapped 0x1C", 32'h1C, 1, 32'hFFFF_FFFF, 4'hF, rd);
        bus("rd unmapped 0x3C", 32'h3C, 0, 0, 4'hF, rd);
        bus("rd INPUT0 after err", 32'h08, 0, 0, 4'hF, rd);
        chk("INPUT0 literal", 256'(rd), 256'(32'h1234_5678));

        // Burst
        burst4(32'h40, 0);

        // Restart while busy
        bus("wr CTRL start A", 32'h00, 1, 32'h3, 4'hF, rd);
        bus("wr CTRL start B", 32'h00, 1, 32'h3, 4'hF, rd);
        chk("busy held", 256'(busy_o), 256'(1));

        // DONE set and clear in the same cycle: set wins
        done_i = 1;
        bus("wr STATUS w1c vs set", 32'h04, 1, 32'h1, 4'hF, rd);
        bus("rd STATUS set wins", 32'h04, 0, 0, 4'hF, rd);
        chk("STATUS set wins literal", 256'(rd), 256'(32'h1));
        done_i = 0;
        chk("irq before rst literal", 256'(irq_o), 256'(1));

        // Reset mid-burst
        burst4(32'h40, 1);
        @(posedge wb_clk); #1;
        wb_rst_n = 1;
        @(posedge wb_clk); #1;
        chk("no term after rst", 256'(wb_ack_o | wb_err_o), 256'(0));
        bus("rd INPUT0 after rst", 32'h08, 0, 0, 4'hF, rd);
        chk("INPUT0 after rst literal", 256'(rd), 256'(32'h0));
        bus("rd CTRL after rst", 32'h00, 0, 0, 4'hF, rd);
        chk("CTRL after rst literal", 256'(rd), 256'(32'h0));

        repeat (2) @(posedge wb_clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
